act_sparse_index_scheduler: RTL and testbench
=============================================

Name: act_sparse_index_scheduler

Overview:
Sequences the 16:1 activation select mux for one sparse compute block. It accepts a 16-bit nonzero bitmap for the block's weights and walks its set bits from LSB to MSB, issuing one activation index per accepted handshake. It also drives a compressed-weight pointer so the PE pairs each selected activation with its stored nonzero weight. Zero-weight positions are skipped entirely, which is the source of the sparsity speed-up.

Parameters:
BLOCK_NUMBER, 16, activations per block and width of the bitmap; fixed at 16 in this revision.
INDEX_WIDTH, 4, width of the mux select, equal to log2(BLOCK_NUMBER).

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  bitmap offered
in_ready  output  1  scheduler can accept a bitmap
in_bitmap  input  BLOCK_NUMBER  bit i = 1 means weight i is nonzero
abort  input  1  synchronous flush of the current block
out_valid  output  1  mask/weight_ptr are valid
out_ready  input  1  PE accepts the current index
mask  output  INDEX_WIDTH  activation index for the select mux
weight_ptr  output  INDEX_WIDTH  offset into the compressed weight list (0 = first nonzero)
out_last  output  1  current index is the block's final one
nz_count  output  INDEX_WIDTH+1  popcount of the captured bitmap (0..16)
blk_done  output  1  one-cycle pulse when a block completes (including an empty block)
blk_empty  output  1  qualifies blk_done: the block had no nonzero weights

Behaviour:
- Reset (synchronous, active-high): state = IDLE, pending = 0. Output values during and after reset:
  - in_ready = 1
  - out_valid = 0, mask = 0, weight_ptr = 0, out_last = 0
  - nz_count = 0, blk_done = 0, blk_empty = 0
- Reset asserted mid-block discards the block; no blk_done is produced.
- All outputs derive from registered state only. There is no combinational path from in_* or out_ready to any output.
- States are IDLE and ISSUE.
- IDLE:
  - in_ready = 1, out_valid = 0, mask = 0.
  - On in_valid & in_ready:
    - pending <= in_bitmap, nz_count <= popcount(in_bitmap), weight_ptr <= 0.
    - If in_bitmap == 0: stay in IDLE; blk_done = 1 and blk_empty = 1 in the next cycle.
    - Otherwise go to ISSUE.
- ISSUE:
  - in_ready = 0; in_valid is ignored and the bitmap is not consumed.
  - out_valid = 1.
  - mask = index of the lowest set bit of pending.
  - out_last = 1 when pending has exactly one bit set.
  - On out_valid & out_ready:
    - Clear that bit in pending.
    - weight_ptr <= weight_ptr + 1.
    - If out_last: go to IDLE; blk_done = 1, blk_empty = 0 in the next cycle.
  - Without out_ready, mask, weight_ptr and out_last hold stable.
- Latency and throughput:
  - Bitmap capture edge to first out_valid: 1 cycle.
  - One index per cycle under continuous out_ready.
  - A block with k nonzeros occupies k+1 cycles: capture, then k issues. blk_done coincides with the first IDLE cycle, so a new bitmap can be captured in that same cycle.
- blk_done and blk_empty are 1-cycle pulses, 0 otherwise.
- weight_ptr never wraps within a block; its maximum is 15 at the 16th issue.
- nz_count holds until the next capture.
- abort:
  - Priority: rst > abort > handshakes.
  - In ISSUE: next cycle state = IDLE, pending = 0, out_valid = 0, no blk_done. A handshake in the same cycle is discarded.
  - In IDLE: a simultaneous in_valid is dropped; in_ready stays 1.
- The mask value is always a legal index 0..15; the downstream mux needs no default case.

Test Plan:
- in_bitmap = 16'h0000 → no out_valid; blk_done = 1 and blk_empty = 1 exactly 1 cycle after capture; nz_count = 0.
- in_bitmap = 16'h8001, out_ready held at 1 → mask 0 then 15, weight_ptr 0 then 1, out_last only on mask 15, nz_count = 2, blk_done 1 cycle after the second issue.
- in_bitmap = 16'hFFFF, out_ready held at 1 → 16 consecutive issues with mask 0..15 and weight_ptr 0..15; blk_done at cycle 17 after capture; a second bitmap captured in the blk_done cycle.
- in_bitmap = 16'h0A50, out_ready toggling 1,0,0,1,... → masks 4, 6, 9, 11 in order, each held stable while out_ready = 0; in_valid pulses during ISSUE are ignored and in_ready stays 0.
- in_bitmap = 16'h00F0, abort after the second handshake → next cycle out_valid = 0, in_ready = 1, no blk_done; a new bitmap 16'h0001 then issues mask 0 with weight_ptr 0.
- rst asserted mid-block on 16'hFFFF at mask 7 → next cycle all outputs at reset values, no blk_done pulse.

Source files
------------

// File: rtl/act_sparse_index_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | act_sparse_index_scheduler                                                 |
// | Walks a 16-bit nonzero-weight bitmap LSB->MSB, issuing one activation      |
// | select index and compressed-weight pointer per accepted handshake.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module act_sparse_index_scheduler #(
  parameter int BLOCK_NUMBER = 16,
  parameter int INDEX_WIDTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BLOCK_NUMBER-1:0]  in_bitmap,
  input  logic                     abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INDEX_WIDTH-1:0]   mask,
  output logic [INDEX_WIDTH-1:0]   weight_ptr,
  output logic                     out_last,
  output logic [INDEX_WIDTH:0]     nz_count,
  output logic                     blk_done,
  output logic                     blk_empty
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]              r_state;
  logic [0:0]              w_state_next;
  logic [BLOCK_NUMBER-1:0] r_pending;
  logic [INDEX_WIDTH-1:0]  r_wptr;
  logic [INDEX_WIDTH:0]    r_nz;
  logic                    r_done;
  logic                    r_empty;

  logic [INDEX_WIDTH-1:0]  w_low_idx;
  logic                    w_one_left;
  logic [INDEX_WIDTH:0]    w_popcount;
  logic                    w_capture;
  logic                    w_issue_hs;

  // Scanning from MSB down leaves the lowest set bit as the final assignment.
  always_comb begin
    w_low_idx = '0;
    for (int i = BLOCK_NUMBER - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_low_idx = INDEX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < BLOCK_NUMBER; i++) begin
      w_popcount = w_popcount + {{INDEX_WIDTH{1'b0}}, in_bitmap[i]};
    end
  end

  assign w_one_left = (r_pending != '0) &&
                      ((r_pending & (r_pending - BLOCK_NUMBER'(1))) == '0);
  assign w_capture  = (r_state == S_IDLE) && in_valid && !abort;
  assign w_issue_hs = (r_state == S_ISSUE) && out_ready && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_capture && (in_bitmap != '0)) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (w_issue_hs && w_one_left) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_wptr    <= '0;
      r_nz      <= '0;
      r_done    <= 1'b0;
      r_empty   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_empty <= 1'b0;
      if (w_capture) begin
        r_pending <= in_bitmap;
        r_nz      <= w_popcount;
        r_wptr    <= '0;
        if (in_bitmap == '0) begin
          r_done  <= 1'b1;
          r_empty <= 1'b1;
        end
      end else if ((r_state == S_ISSUE) && abort) begin
        r_pending <= '0;
      end else if (w_issue_hs) begin
        r_pending <= r_pending & (r_pending - BLOCK_NUMBER'(1));
        // Final issue holds the pointer so it never wraps past 15.
        if (w_one_left) begin
          r_done <= 1'b1;
        end else begin
          r_wptr <= r_wptr + INDEX_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    mask      = '0;
    out_last  = 1'b0;
    case (r_state)
      S_ISSUE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        mask      = w_low_idx;
        out_last  = w_one_left;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  assign weight_ptr = r_wptr;
  assign nz_count   = r_nz;
  assign blk_done   = r_done;
  assign blk_empty  = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_act_sparse_index_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_act_sparse_index_scheduler                                              |
// | Directed self-checking bench for the sparse index scheduler.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_act_sparse_index_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bitmap;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  mask;
  logic [3:0]  weight_ptr;
  logic        out_last;
  logic [4:0]  nz_count;
  logic        blk_done;
  logic        blk_empty;

  int n_checks = 0;
  int n_fail   = 0;

  act_sparse_index_scheduler #(.BLOCK_NUMBER(16), .INDEX_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_bitmap(in_bitmap), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .mask(mask), .weight_ptr(weight_ptr),
    .out_last(out_last), .nz_count(nz_count), .blk_done(blk_done),
    .blk_empty(blk_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"},   in_ready,   1);
    chk({tag, " out_valid"},  out_valid,  0);
    chk({tag, " mask"},       mask,       0);
    chk({tag, " weight_ptr"}, weight_ptr, 0);
    chk({tag, " out_last"},   out_last,   0);
    chk({tag, " nz_count"},   nz_count,   0);
    chk({tag, " blk_done"},   blk_done,   0);
    chk({tag, " blk_empty"},  blk_empty,  0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bitmap = '0; abort = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Empty block
    in_valid = 1'b1; in_bitmap = 16'h0000;
    tick();
    in_valid = 1'b0;
    chk("empty out_valid", out_valid, 0);
    chk("empty blk_done",  blk_done,  1);
    chk("empty blk_empty", blk_empty, 1);
    chk("empty nz_count",  nz_count,  0);
    chk("empty in_ready",  in_ready,  1);
    tick();
    chk("empty done pulse ends", blk_done, 0);

    // 8001 with continuous out_ready
    in_valid = 1'b1; in_bitmap = 16'h8001; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("8001 v0",    out_valid,  1);
    chk("8001 m0",    mask,       0);
    chk("8001 p0",    weight_ptr, 0);
    chk("8001 l0",    out_last,   0);
    chk("8001 nz",    nz_count,   2);
    chk("8001 rdy0",  in_ready,   0);
    chk("8001 done0", blk_done,   0);
    tick();
    chk("8001 m1", mask,       15);
    chk("8001 p1", weight_ptr, 1);
    chk("8001 l1", out_last,   1);
    tick();
    chk("8001 idle v",  out_valid, 0);
    chk("8001 done",    blk_done,  1);
    chk("8001 empty",   blk_empty, 0);

    // FFFF, back-to-back capture in the blk_done cycle
    in_valid = 1'b1; in_bitmap = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    chk("ffff nz", nz_count, 16);
    for (int i = 0; i < 16; i++) begin
      chk("ffff valid", out_valid,  1);
      chk("ffff mask",  mask,       i);
      chk("ffff wptr",  weight_ptr, i);
      chk("ffff last",  out_last,   (i == 15) ? 1 : 0);
      chk("ffff nodone", blk_done,  0);
      tick();
    end
    chk("ffff done",     blk_done, 1);
    chk("ffff in_ready", in_ready, 1);
    in_valid = 1'b1; in_bitmap = 16'h0003;
    tick();
    in_valid = 1'b0;
    chk("b2b valid", out_valid, 1);
    chk("b2b mask",  mask,      0);
    chk("b2b nz",    nz_count,  2);
    chk("b2b wptr",  weight_ptr, 0);
    tick();
    chk("b2b mask1", mask, 1);
    tick();
    chk("b2b done", blk_done, 1);

    // 0A50 with stalls and ignored in_valid during ISSUE
    in_valid = 1'b1; in_bitmap = 16'h0A50; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("0a50 m4",   mask, 4);
    chk("0a50 nz",   nz_count, 4);
    out_ready = 1'b1;
    tick();
    chk("0a50 m6",   mask, 6);
    chk("0a50 p1",   weight_ptr, 1);
    out_ready = 1'b0; in_valid = 1'b1; in_bitmap = 16'hFFFF;
    tick();
    chk("0a50 hold m6a", mask, 6);
    chk("0a50 hold p1",  weight_ptr, 1);
    chk("0a50 rdy low",  in_ready, 0);
    chk("0a50 nz keep",  nz_count, 4);
    tick();
    chk("0a50 hold m6b", mask, 6);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("0a50 m9",  mask, 9);
    chk("0a50 p2",  weight_ptr, 2);
    out_ready = 1'b0;
    tick();
    chk("0a50 hold m9", mask, 9);
    chk("0a50 l9",      out_last, 0);
    out_ready = 1'b1;
    tick();
    chk("0a50 m11", mask, 11);
    chk("0a50 p3",  weight_ptr, 3);
    chk("0a50 l11", out_last, 1);
    tick();
    chk("0a50 done", blk_done, 1);

    // 00F0 aborted after two handshakes
    in_valid = 1'b1; in_bitmap = 16'h00F0;
    tick();
    in_valid = 1'b0;
    chk("abt m4", mask, 4);
    tick();
    chk("abt m5", mask, 5);
    tick();
    chk("abt m6", mask, 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt valid", out_valid, 0);
    chk("abt ready", in_ready,  1);
    chk("abt nodone", blk_done, 0);
    tick();
    chk("abt nodone2", blk_done, 0);
    chk("abt valid2",  out_valid, 0);
    in_valid = 1'b1; in_bitmap = 16'h0001;
    tick();
    in_valid = 1'b0;
    chk("post mask", mask, 0);
    chk("post wptr", weight_ptr, 0);
    chk("post last", out_last, 1);
    chk("post nz",   nz_count, 1);
    tick();
    chk("post done", blk_done, 1);

    // abort in IDLE drops a simultaneous bitmap
    abort = 1'b1; in_valid = 1'b1; in_bitmap = 16'h0003;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("idle abt valid", out_valid, 0);
    chk("idle abt ready", in_ready,  1);
    chk("idle abt nz",    nz_count,  1);
    chk("idle abt done",  blk_done,  0);

    // Reset mid-block
    in_valid = 1'b1; in_bitmap = 16'hFFFF; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("rstmid m7", mask, 7);
    chk("rstmid p7", weight_ptr, 7);
    rst = 1'b1;
    tick();
    chk_reset_vals("rstmid");
    rst = 1'b0;
    tick();
    chk("rstmid nodone", blk_done,  0);
    chk("rstmid valid",  out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
